rf_forward_bank: RTL and testbench
==================================

Name: rf_forward_bank

Overview:
- Parametrised successor to the pipeline's register file and PA/PB/PD hazard muxes.
- Combines three pieces in one block:
  - a multi-port register array with a synchronous WB write port;
  - per-port EX/MEM/WB bypass selection;
  - load-use stall detection.
- Adds saturating stall and forward event counters for pipeline validation.
- Sits in the ID stage. It feeds the ID/EX register and drives the PC/IF-ID load enables.

Parameters:
- DATA_W, 32, register and bypass data width
- ADDR_W, 4, register index width
- NREGS, 16, number of architectural registers (at most 2**ADDR_W)
- NRD, 3, number of read ports (PA, PB, PD)
- PC_REG, 15, index that reads the PC value instead of array storage
- CNT_W, 16, event counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NRD*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_used  in  NRD  port i is consumed by the ID instruction; qualifies stall and counters
- rd_data  out  NRD*DATA_W  read data after bypass
- fwd_sel  out  NRD*2  per-port source: 0 array/PC, 1 EX, 2 MEM, 3 WB
- pc_val  in  DATA_W  value returned for PC_REG reads
- ex_rd, mem_rd, wb_rd  in  ADDR_W  destination index in EX, MEM, WB
- ex_rf_e, mem_rf_e, wb_rf_e  in  1  destination write enable in each stage
- ex_load  in  1  EX instruction is a load
- ex_result, mem_result, wb_result  in  DATA_W  stage result; mem_result is after the data-memory mux
- stall  out  1  load-use hazard; deasserts PC enable and IF/ID enable, inserts NOP into EX
- cnt_clr  in  1  synchronous clear of both counters
- stall_cnt, fwd_cnt  out  CNT_W  event counters

Behaviour:
- Reset:
  - all array entries become 0;
  - stall_cnt and fwd_cnt become 0.
  - rd_data, fwd_sel and stall are combinational and follow the inputs during reset.
  - WB writes are ignored while reset=1.
- WB write:
  - on a rising edge with wb_rf_e=1, wb_rd!=PC_REG and wb_rd<NREGS, the array entry at wb_rd takes wb_result;
  - the new value is visible through the array on the next cycle;
  - a WB write to PC_REG is dropped, because the PC is owned by the PC module.
- Read, per port i, with a = rd_addr[i] (combinational, zero latency):
  - a==PC_REG: rd_data = pc_val, fwd_sel = 0, no bypass.
  - a>=NREGS: rd_data = 0, fwd_sel = 0.
  - otherwise apply the first matching priority:
    1. ex_rf_e && ex_rd==a && !ex_load gives EX (sel 1, ex_result).
    2. mem_rf_e && mem_rd==a gives MEM (sel 2).
    3. wb_rf_e && wb_rd==a gives WB (sel 3). This covers same-cycle write-through.
    4. Otherwise the array value.
  - An EX load match never selects EX. The port falls through to MEM/WB/array, and stall covers the hazard.
- Stall:
  - stall=1 iff there is a port i with:
    - rd_used[i]=1;
    - ex_rf_e=1 and ex_load=1;
    - ex_rd==rd_addr[i];
    - rd_addr[i]!=PC_REG.
  - The pipeline holds ID one cycle and EX gets a NOP, so on the next cycle the load is in MEM and is forwarded with sel 2.
  - Multiple matching ports still produce a single stall.
- Counters, updated on the rising edge:
  - stall_cnt += 1 when stall=1.
  - fwd_cnt += number of ports with rd_used[i]=1 and fwd_sel[i]!=0, computed in the same cycle.
  - Both counters saturate at 2**CNT_W-1; an addition never wraps.
  - Priority: reset > cnt_clr > increment. cnt_clr zeroes both counters, and any concurrent event is discarded.
- Reset mid-stall: the array and counters clear on that edge. stall continues to reflect its inputs, and the surrounding pipeline reset clears the EX stage.

Decomposition:
- Shared package: fwd_sel encodings (FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3) and the PC_REG default.
- Sub-module rf_bypass_mux:
  - one instance per read port via generate;
  - inputs: address, the three stage tuples, array word and pc_val;
  - outputs: data, sel and a load-hit flag.
- Array, stall OR-reduction and counters live in the top module.

Test Plan:
1. Reset, then write R1=5 via WB, then read port0 addr 1 with no hazards -> rd_data0=5, fwd_sel0=0. A read of R1 during the reset cycle returns 0.
2. EX writes R2=0xAA (non-load), MEM R2=0xBB, WB R2=0xCC, port1 addr 2 -> 0xAA sel 1. Drop ex_rf_e -> 0xBB sel 2. Drop mem_rf_e -> 0xCC sel 3.
3. EX load to R3, port0 rd_used=1 addr 3 -> stall=1, stall_cnt 0->1. Next cycle with the load in MEM, mem_result=0x1234 -> stall=0, rd_data0=0x1234, sel 2.
4. Same EX load to R3 but rd_used0=0; separately, rd_addr=15 with ex_rd=15 -> stall=0 in both cases. The addr-15 read returns pc_val=0x40, sel 0. A WB write to R15 leaves subsequent reads at pc_val.
5. CNT_W=2, three ports forwarding for two cycles -> fwd_cnt saturates at 3. Assert cnt_clr while a stall is present -> both counters 0 the next cycle.
6. WB write R4=7 and a same-cycle read of R4 -> 7 sel 3. The next cycle, with no hazards, reads 7 sel 0.

Source files
------------

// File: rtl/rf_forward_bank_pkg.sv
// Shared definitions for the register-file / forwarding bank.
//   fwd_sel_e     : per-port bypass source encoding driven on fwd_sel
//   PC_REG_DEFAULT: register index that reads the PC instead of storage
package rf_forward_bank_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,     // array word or PC value
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    localparam int PC_REG_DEFAULT = 15;

endpackage

// File: rtl/rf_forward_bank_if.sv
// ID-stage bus between the decode/hazard logic and the register bank.
//   rd_addr/rd_used   : read indices and "operand consumed" qualifiers
//   rd_data/fwd_sel   : bypassed read data and its selected source
//   pc_val            : value returned for PC-index reads
//   ex_*/mem_*/wb_*   : destination index, write enable and result per stage
//   ex_load           : EX instruction is a load
//   stall             : load-use hazard towards PC / IF-ID enables
// master = pipeline side, slave = register bank.
interface rf_forward_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NRD    = 3
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD-1:0]        rd_used;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD*2-1:0]      fwd_sel;
    logic [DATA_W-1:0]     pc_val;
    logic [ADDR_W-1:0]     ex_rd;
    logic [ADDR_W-1:0]     mem_rd;
    logic [ADDR_W-1:0]     wb_rd;
    logic                  ex_rf_e;
    logic                  mem_rf_e;
    logic                  wb_rf_e;
    logic                  ex_load;
    logic [DATA_W-1:0]     ex_result;
    logic [DATA_W-1:0]     mem_result;
    logic [DATA_W-1:0]     wb_result;
    logic                  stall;

    modport master (
        output rd_addr, rd_used, pc_val,
        output ex_rd, mem_rd, wb_rd, ex_rf_e, mem_rf_e, wb_rf_e, ex_load,
        output ex_result, mem_result, wb_result,
        input  rd_data, fwd_sel, stall
    );

    modport slave (
        input  rd_addr, rd_used, pc_val,
        input  ex_rd, mem_rd, wb_rd, ex_rf_e, mem_rf_e, wb_rf_e, ex_load,
        input  ex_result, mem_result, wb_result,
        output rd_data, fwd_sel, stall
    );
endinterface

// File: rtl/rf_bypass_mux.sv
// Per-read-port bypass selection (purely combinational).
//   addr            : register index read by this port
//   ex_*/mem_*/wb_* : stage destination tuples and results
//   arr_data        : array word at addr (0 when addr is out of range)
//   pc_val          : value returned for PC_REG reads
//   data/sel        : bypassed value and its source
//   load_hit        : EX holds a load targeting this (non-PC) index
module rf_bypass_mux
    import rf_forward_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16,
    parameter int PC_REG = PC_REG_DEFAULT
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_rf_e,
    input  logic              ex_load,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_rf_e,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_rf_e,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [DATA_W-1:0] arr_data,
    input  logic [DATA_W-1:0] pc_val,
    output logic [DATA_W-1:0] data,
    output fwd_sel_e          sel,
    output logic              load_hit
);
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(PC_REG);

    logic is_pc;
    assign is_pc    = (addr == PC_IDX);
    assign load_hit = ex_rf_e && ex_load && (ex_rd == addr) && !is_pc;

    always_comb begin
        data = '0;
        sel  = FWD_RF;
        if (is_pc) begin
            data = pc_val;
        end else if (int'(addr) >= NREGS) begin
            data = '0;
        end else if (ex_rf_e && (ex_rd == addr) && !ex_load) begin
            // A load in EX has no data yet; it falls through and stall covers it.
            data = ex_result;
            sel  = FWD_EX;
        end else if (mem_rf_e && (mem_rd == addr)) begin
            data = mem_result;
            sel  = FWD_MEM;
        end else if (wb_rf_e && (wb_rd == addr)) begin
            // Same-cycle write-through: the array only updates at the edge.
            data = wb_result;
            sel  = FWD_WB;
        end else begin
            data = arr_data;
        end
    end
endmodule

// File: rtl/rf_forward_bank.sv
// ID-stage register file with EX/MEM/WB bypass, load-use stall and
// saturating validation counters.
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : read ports, stage tuples, pc_val, stall
//   cnt_clr             : synchronous clear of both counters
//   stall_cnt, fwd_cnt  : saturating event counters
module rf_forward_bank
    import rf_forward_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16,
    parameter int NRD    = 3,
    parameter int PC_REG = PC_REG_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    rf_forward_bank_if.slave     bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     fwd_cnt
);
    localparam logic [ADDR_W-1:0] PC_IDX  = ADDR_W'(PC_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam int                EV_W    = $clog2(NRD + 1);
    localparam int                SUM_W   = CNT_W + EV_W;

    logic [DATA_W-1:0] regs_reg [NREGS];
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  fwd_cnt_reg, fwd_cnt_next;

    logic [DATA_W-1:0] arr_word   [NRD];
    fwd_sel_e          sel_w      [NRD];
    logic [NRD-1:0]    load_hit_w;
    logic [EV_W-1:0]   fwd_events;
    logic [SUM_W-1:0]  fwd_sum;
    logic              wb_we;

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [ADDR_W-1:0] addr;
            assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];
            assign arr_word[gi] = (int'(addr) < NREGS) ? regs_reg[addr] : '0;

            rf_bypass_mux #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NREGS  (NREGS),
                .PC_REG (PC_REG)
            ) u_mux (
                .addr       (addr),
                .ex_rd      (bus.ex_rd),
                .ex_rf_e    (bus.ex_rf_e),
                .ex_load    (bus.ex_load),
                .ex_result  (bus.ex_result),
                .mem_rd     (bus.mem_rd),
                .mem_rf_e   (bus.mem_rf_e),
                .mem_result (bus.mem_result),
                .wb_rd      (bus.wb_rd),
                .wb_rf_e    (bus.wb_rf_e),
                .wb_result  (bus.wb_result),
                .arr_data   (arr_word[gi]),
                .pc_val     (bus.pc_val),
                .data       (bus.rd_data[gi*DATA_W +: DATA_W]),
                .sel        (sel_w[gi]),
                .load_hit   (load_hit_w[gi])
            );

            assign bus.fwd_sel[gi*2 +: 2] = sel_w[gi];
        end
    endgenerate

    // Only consumed operands can cause a load-use hazard.
    assign bus.stall = |(load_hit_w & bus.rd_used);

    // The PC is owned elsewhere, so writes aimed at it are dropped.
    assign wb_we = bus.wb_rf_e && (bus.wb_rd != PC_IDX) && (int'(bus.wb_rd) < NREGS);

    always_comb begin
        fwd_events = '0;
        for (int i = 0; i < NRD; i++) begin
            if (bus.rd_used[i] && (sel_w[i] != FWD_RF))
                fwd_events = fwd_events + EV_W'(1);
        end
    end

    // Wide sum so a saturating add can never wrap before the clamp.
    assign fwd_sum      = SUM_W'(fwd_cnt_reg) + SUM_W'(fwd_events);
    assign fwd_cnt_next = (fwd_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : fwd_sum[CNT_W-1:0];
    assign stall_cnt_next = (bus.stall && (stall_cnt_reg != CNT_MAX))
                          ? stall_cnt_reg + CNT_W'(1) : stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs_reg[i] <= '0;
            stall_cnt_reg <= '0;
            fwd_cnt_reg   <= '0;
        end else begin
            if (wb_we)
                regs_reg[bus.wb_rd] <= bus.wb_result;
            if (cnt_clr) begin
                stall_cnt_reg <= '0;
                fwd_cnt_reg   <= '0;
            end else begin
                stall_cnt_reg <= stall_cnt_next;
                fwd_cnt_reg   <= fwd_cnt_next;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign fwd_cnt   = fwd_cnt_reg;
endmodule

// File: tb/tb_rf_forward_bank.sv
module tb_rf_forward_bank;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NRD    = 3;
    localparam int CNT_W  = 2;

    logic clk = 1'b0;
    logic reset;
    logic cnt_clr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    int tests = 0;
    int fails = 0;

    rf_forward_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) bus ();

    rf_forward_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (16),
        .NRD    (NRD),
        .PC_REG (15),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] data_of(input int p);
        return bus.rd_data[p*DATA_W +: DATA_W];
    endfunction

    function automatic logic [31:0] sel_of(input int p);
        return 32'(bus.fwd_sel[p*2 +: 2]);
    endfunction

    task automatic set_addr(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        bus.rd_addr = {a2, a1, a0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cnt_clr = 1'b0;
        bus.rd_addr = '0; bus.rd_used = '0; bus.pc_val = 32'h40;
        bus.ex_rd = '0; bus.mem_rd = '0; bus.wb_rd = '0;
        bus.ex_rf_e = 1'b0; bus.mem_rf_e = 1'b0; bus.wb_rf_e = 1'b0; bus.ex_load = 1'b0;
        bus.ex_result = '0; bus.mem_result = '0; bus.wb_result = '0;

        // 1: reset, write during reset is dropped, then WB write R1=5
        bus.wb_rf_e = 1'b1; bus.wb_rd = 4'd1; bus.wb_result = 32'h99;
        set_addr(4'd1, 4'd0, 4'd0);
        tick(); tick();
        bus.wb_rf_e = 1'b0;
        #1;
        chk("reset_read_r1", data_of(0), 32'h0);
        chk("reset_sel0", sel_of(0), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_fwd_cnt", 32'(fwd_cnt), 32'd0);
        reset = 1'b0;
        bus.wb_rf_e = 1'b1; bus.wb_rd = 4'd1; bus.wb_result = 32'd5;
        tick();
        bus.wb_rf_e = 1'b0;
        #1;
        chk("r1_data", data_of(0), 32'd5);
        chk("r1_sel", sel_of(0), 32'd0);

        // 2: bypass priority EX > MEM > WB on port1
        set_addr(4'd0, 4'd2, 4'd0);
        bus.ex_rf_e = 1'b1;  bus.ex_rd = 4'd2;  bus.ex_result = 32'hAA;
        bus.mem_rf_e = 1'b1; bus.mem_rd = 4'd2; bus.mem_result = 32'hBB;
        bus.wb_rf_e = 1'b1;  bus.wb_rd = 4'd2;  bus.wb_result = 32'hCC;
        #1;
        chk("prio_ex_data", data_of(1), 32'hAA);
        chk("prio_ex_sel", sel_of(1), 32'd1);
        bus.ex_rf_e = 1'b0; #1;
        chk("prio_mem_data", data_of(1), 32'hBB);
        chk("prio_mem_sel", sel_of(1), 32'd2);
        bus.mem_rf_e = 1'b0; #1;
        chk("prio_wb_data", data_of(1), 32'hCC);
        chk("prio_wb_sel", sel_of(1), 32'd3);
        bus.wb_rf_e = 1'b0;

        // 3: load-use stall, then load forwarded from MEM
        set_addr(4'd3, 4'd0, 4'd0);
        bus.rd_used = 3'b001;
        bus.ex_rf_e = 1'b1; bus.ex_load = 1'b1; bus.ex_rd = 4'd3; bus.ex_result = 32'hDEAD;
        #1;
        chk("lu_stall", 32'(bus.stall), 32'd1);
        chk("lu_no_ex_sel", sel_of(0), 32'd0);
        chk("lu_stall_cnt_pre", 32'(stall_cnt), 32'd0);
        tick();
        chk("lu_stall_cnt_post", 32'(stall_cnt), 32'd1);
        chk("lu_fwd_cnt_post", 32'(fwd_cnt), 32'd0);
        bus.ex_rf_e = 1'b0; bus.ex_load = 1'b0;
        bus.mem_rf_e = 1'b1; bus.mem_rd = 4'd3; bus.mem_result = 32'h1234;
        #1;
        chk("lu_mem_stall", 32'(bus.stall), 32'd0);
        chk("lu_mem_data", data_of(0), 32'h1234);
        chk("lu_mem_sel", sel_of(0), 32'd2);
        tick();
        chk("lu_fwd_cnt", 32'(fwd_cnt), 32'd1);
        chk("lu_stall_cnt_hold", 32'(stall_cnt), 32'd1);
        bus.mem_rf_e = 1'b0; bus.rd_used = 3'b000;

        // 4: unused operand and PC index never stall; PC reads bypass nothing
        bus.ex_rf_e = 1'b1; bus.ex_load = 1'b1; bus.ex_rd = 4'd3;
        #1;
        chk("unused_no_stall", 32'(bus.stall), 32'd0);
        set_addr(4'd15, 4'd15, 4'd15);
        bus.rd_used = 3'b111; bus.ex_rd = 4'd15;
        #1;
        chk("pc_no_stall", 32'(bus.stall), 32'd0);
        chk("pc_data", data_of(0), 32'h40);
        chk("pc_sel", sel_of(0), 32'd0);
        bus.ex_load = 1'b0; bus.ex_result = 32'hAA;
        #1;
        chk("pc_no_ex_bypass", data_of(2), 32'h40);
        bus.wb_rf_e = 1'b1; bus.wb_rd = 4'd15; bus.wb_result = 32'h77;
        #1;
        chk("pc_no_wb_bypass", data_of(1), 32'h40);
        tick();
        bus.wb_rf_e = 1'b0; bus.ex_rf_e = 1'b0;
        #1;
        chk("pc_after_wb", data_of(0), 32'h40);
        chk("pc_cnt_unchanged", 32'(fwd_cnt), 32'd1);

        // 5: fwd_cnt saturation (1+3 clamps to 3), cnt_clr over stall, stall_cnt saturation
        set_addr(4'd5, 4'd5, 4'd5);
        bus.ex_rf_e = 1'b1; bus.ex_load = 1'b0; bus.ex_rd = 4'd5; bus.ex_result = 32'h55;
        #1;
        chk("sat_ex_data2", data_of(2), 32'h55);
        chk("sat_ex_sel2", sel_of(2), 32'd1);
        tick();
        chk("sat_fwd_1", 32'(fwd_cnt), 32'd3);
        tick();
        chk("sat_fwd_2", 32'(fwd_cnt), 32'd3);
        bus.ex_load = 1'b1;
        #1;
        chk("clr_stall_present", 32'(bus.stall), 32'd1);
        cnt_clr = 1'b1;
        tick();
        chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("clr_fwd_cnt", 32'(fwd_cnt), 32'd0);
        cnt_clr = 1'b0;
        tick(); tick(); tick(); tick();
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("sat_stall_fwd", 32'(fwd_cnt), 32'd0);
        bus.ex_rf_e = 1'b0; bus.ex_load = 1'b0; bus.rd_used = 3'b000;

        // 6: same-cycle write-through then array read
        set_addr(4'd4, 4'd2, 4'd1);
        bus.wb_rf_e = 1'b1; bus.wb_rd = 4'd4; bus.wb_result = 32'd7;
        #1;
        chk("wt_data", data_of(0), 32'd7);
        chk("wt_sel", sel_of(0), 32'd3);
        tick();
        bus.wb_rf_e = 1'b0;
        #1;
        chk("arr_r4_data", data_of(0), 32'd7);
        chk("arr_r4_sel", sel_of(0), 32'd0);
        chk("arr_r2_data", data_of(1), 32'd0);
        chk("arr_r1_data", data_of(2), 32'd5);

        // Reset mid-run clears the array
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_r4_cleared", data_of(0), 32'd0);
        chk("rst_r1_cleared", data_of(2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
